// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunked multi-cycle adder/subtractor:
// state encoding and a counter-width helper.
package seq_chunk_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_rca.sv
// Combinational CHUNK-bit ripple-carry slice built from full adders; also exposes
// the carry into the top bit so the caller can derive signed overflow.
module chunk_rca #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed CHUNK bits per clock,
// with valid/ready handshakes on both sides.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for operands
//   RUN   | one slice per edge, carry held in carry_q
//   DONE  | out_valid=1, result held until out_ready
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int KW         = idx_width(NUM_CHUNKS);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_CHUNKS - 1);

  if (CHUNK < 1 || NUM_CHUNKS < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic [KW-1:0]    k;
  logic             carry_q, cout_q, ovf_q;

  logic [CHUNK-1:0] a_sl, b_sl, sum_sl;
  logic             c_out_sl, c_msb_sl;

  assign a_sl = a_q[k*CHUNK +: CHUNK];
  assign b_sl = b_q[k*CHUNK +: CHUNK];

  chunk_rca #(.CHUNK(CHUNK)) u_rca (
    .a        (a_sl),
    .b        (b_sl),
    .cin      (carry_q),
    .s        (sum_sl),
    .cout     (c_out_sl),
    .c_msb_in (c_msb_sl)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (k == K_LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: invert B at capture and seed the carry with sub.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      k       <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= B ^ {WIDTH{sub}};
            carry_q <= sub;
            k       <= '0;
          end
        end
        RUN: begin
          s_q[k*CHUNK +: CHUNK] <= sum_sl;
          carry_q               <= c_out_sl;
          k                     <= k + KW'(1);
          if (k == K_LAST) begin
            cout_q <= c_out_sl;
            ovf_q  <= c_msb_sl ^ c_out_sl;
          end
        end
        default: ;
      endcase
    end
  end

  assign S    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
